// File: rtl/imm_gen_pipe.sv
// Pipelined multi-lane immediate generator: forms immediates, PC-relative targets and
// fault flags through a two-stage elastic valid/ready pipeline with synchronous flush.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_instr,
    input  logic [LANES*3-1:0]    in_mode,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*XLEN-1:0] out_imm,
    output logic [LANES*XLEN-1:0] out_target,
    output logic [LANES-1:0]      out_misalign,
    output logic [LANES-1:0]      out_illegal
);

    localparam logic [2:0] MODE_R  = 3'b000;
    localparam logic [2:0] MODE_I  = 3'b001;
    localparam logic [2:0] MODE_S  = 3'b010;
    localparam logic [2:0] MODE_B  = 3'b011;
    localparam logic [2:0] MODE_U  = 3'b100;
    localparam logic [2:0] MODE_J  = 3'b101;
    localparam logic [2:0] MODE_Z  = 3'b110;
    localparam logic [2:0] MODE_SH = 3'b111;

    // Built at 64 bits and truncated, so one body serves both datapath widths.
    function automatic logic [XLEN-1:0] form_imm(input logic [31:0] instr,
                                                 input logic [2:0]  mode);
        logic [63:0] imm64;
        imm64 = '0;
        case (mode)
            MODE_R:  imm64 = '0;
            MODE_I:  imm64 = {{52{instr[31]}}, instr[31:20]};
            MODE_S:  imm64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            MODE_B:  imm64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            MODE_U:  imm64 = {{32{instr[31]}}, instr[31:12], 12'b0};
            MODE_J:  imm64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            MODE_Z:  imm64 = {59'b0, instr[19:15]};
            MODE_SH: begin
                if (XLEN == 32) imm64 = {59'b0, instr[24:20]};
                else            imm64 = {58'b0, instr[25:20]};
            end
            default: imm64 = '0;
        endcase
        return imm64[XLEN-1:0];
    endfunction

    // Handshake
    logic s1_valid, s2_valid;
    logic adv1, adv2, accept;

    assign adv2      = !s2_valid | out_ready;
    assign adv1      = !s1_valid | adv2;
    assign in_ready  = adv1;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;

    // Stage 1 next-state, formed directly from the input beat
    logic [LANES-1:0][XLEN-1:0] s1_imm_d, s1_pc_d;
    logic [LANES-1:0][2:0]      s1_mode_d;
    logic [LANES-1:0]           s1_illegal_d;

    always_comb begin
        s1_imm_d     = '0;
        s1_pc_d      = '0;
        s1_mode_d    = '0;
        s1_illegal_d = '0;
        for (int l = 0; l < LANES; l++) begin
            s1_imm_d[l]  = form_imm(in_instr[32*l +: 32], in_mode[3*l +: 3]);
            s1_pc_d[l]   = in_pc + XLEN'(4 * l);
            s1_mode_d[l] = in_mode[3*l +: 3];
            // instr[25] is dropped from the 32-bit shamt, so the fault is captured here
            s1_illegal_d[l] = (XLEN == 32) && (in_mode[3*l +: 3] == MODE_SH) &&
                              in_instr[32*l + 25];
        end
    end

    logic [LANES-1:0][XLEN-1:0] s1_imm, s1_pc;
    logic [LANES-1:0][2:0]      s1_mode;
    logic [LANES-1:0]           s1_illegal;

    // Stage 2 next-state
    logic [LANES-1:0][XLEN-1:0] s2_target_d;
    logic [LANES-1:0]           s2_misalign_d;

    always_comb begin
        s2_target_d   = '0;
        s2_misalign_d = '0;
        for (int l = 0; l < LANES; l++) begin
            s2_target_d[l]   = s1_pc[l] + s1_imm[l];
            s2_misalign_d[l] = ((s1_mode[l] == MODE_B) || (s1_mode[l] == MODE_J)) &&
                               (s2_target_d[l][1:0] != 2'b00);
        end
    end

    logic [LANES-1:0][XLEN-1:0] s2_imm, s2_target;
    logic [LANES-1:0]           s2_misalign, s2_illegal;

    // Valid bits; flush outranks acceptance and advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (adv1) s1_valid <= in_valid;
            if (adv2) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_imm     <= '0;
            s1_pc      <= '0;
            s1_mode    <= '0;
            s1_illegal <= '0;
        end else if (accept && !flush) begin
            s1_imm     <= s1_imm_d;
            s1_pc      <= s1_pc_d;
            s1_mode    <= s1_mode_d;
            s1_illegal <= s1_illegal_d;
        end
    end

    // Loads only on advance, so a stalled output beat holds stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_imm      <= '0;
            s2_target   <= '0;
            s2_misalign <= '0;
            s2_illegal  <= '0;
        end else if (adv2 && s1_valid && !flush) begin
            s2_imm      <= s1_imm;
            s2_target   <= s2_target_d;
            s2_misalign <= s2_misalign_d;
            s2_illegal  <= s1_illegal;
        end
    end

    assign out_imm      = s2_imm;
    assign out_target   = s2_target;
    assign out_misalign = s2_misalign;
    assign out_illegal  = s2_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: a 2-lane XLEN=32 instance with a queue-based
// reference model, plus a 1-lane XLEN=64 instance checked from vectors and the model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit, 2-lane instance
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_instr;
    logic [5:0]  in_mode;
    logic [31:0] in_pc;
    logic [63:0] out_imm, out_target;
    logic [1:0]  out_misalign, out_illegal;

    // 64-bit, 1-lane instance
    logic        flush_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [31:0] in_instr_w;
    logic [2:0]  in_mode_w;
    logic [63:0] in_pc_w, out_imm_w, out_target_w;
    logic        out_misalign_w, out_illegal_w;

    imm_gen_pipe #(.XLEN(32), .LANES(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_mode(in_mode), .in_pc(in_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_target(out_target),
        .out_misalign(out_misalign), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .LANES(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush_w), .in_valid(in_valid_w),
        .in_ready(in_ready_w), .in_instr(in_instr_w), .in_mode(in_mode_w), .in_pc(in_pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_imm(out_imm_w),
        .out_target(out_target_w), .out_misalign(out_misalign_w),
        .out_illegal(out_illegal_w)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: immediates as signed integer values from the format rules
    function automatic longint sx(input longint v, input int n);
        if (v >= (longint'(1) << (n - 1))) return v - (longint'(1) << n);
        return v;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] m,
                                            input bit x64);
        longint      v;
        logic [63:0] u;
        case (m)
            3'd0: v = 0;
            3'd1: v = sx(longint'(ins[31:20]), 12);
            3'd2: v = sx(longint'({ins[31:25], ins[11:7]}), 12);
            3'd3: v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
            3'd4: v = sx(longint'(ins[31:12]) * 4096, 32);
            3'd5: v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            3'd6: v = longint'(ins[19:15]);
            default: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
        endcase
        u = v;
        return x64 ? u : (u & 64'hFFFF_FFFF);
    endfunction

    typedef struct {
        logic [1:0][31:0] imm;
        logic [1:0][31:0] tgt;
        logic [1:0]       mis;
        logic [1:0]       ill;
        int               acc;
    } exp_t;

    function automatic exp_t predict(input logic [63:0] ins, input logic [5:0] md,
                                     input logic [31:0] pc, input int acc);
        exp_t        e;
        logic [63:0] imm, t;
        logic [31:0] ii;
        logic [2:0]  m;
        for (int l = 0; l < 2; l++) begin
            ii = ins[32*l +: 32];
            m  = md[3*l +: 3];
            imm = ref_imm(ii, m, 1'b0);
            t   = ({32'b0, pc} + 64'(4 * l) + imm) & 64'hFFFF_FFFF;
            e.imm[l] = imm[31:0];
            e.tgt[l] = t[31:0];
            e.mis[l] = ((m == 3'd3) || (m == 3'd5)) && (t[1:0] != 2'b00);
            e.ill[l] = (m == 3'd7) && ii[25];
        end
        e.acc = acc;
        return e;
    endfunction

    exp_t q[$];
    int   cycle = 0;

    // One clock of the 32-bit instance, checked against the in-flight queue
    task automatic cyc(input bit v, input logic [63:0] ins, input logic [5:0] md,
                       input logic [31:0] pc, input bit ordy, input bit fl, output bit acc);
        bit exp_ov, exp_ir;
        in_valid = v; in_instr = ins; in_mode = md; in_pc = pc;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        exp_ov = (q.size() > 0) && (q[0].acc <= cycle - 2);
        exp_ir = (q.size() < 2) || ordy;
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, exp_ir);
        if (exp_ov && out_valid) begin
            for (int l = 0; l < 2; l++) begin
                chk($sformatf("imm[%0d]", l), out_imm[32*l +: 32], q[0].imm[l]);
                chk($sformatf("target[%0d]", l), out_target[32*l +: 32], q[0].tgt[l]);
                chk($sformatf("misalign[%0d]", l), out_misalign[l], q[0].mis[l]);
                chk($sformatf("illegal[%0d]", l), out_illegal[l], q[0].ill[l]);
            end
        end
        if (exp_ov && ordy) void'(q.pop_front());
        acc = v && exp_ir && !fl;
        if (fl) q.delete();
        else if (acc) q.push_back(predict(ins, md, pc, cycle));
        @(posedge clk);
        cycle++;
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  mode;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        mis;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  mode;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        mis;
        logic        ill;
    } vec64_t;

    vec_t   tbl[11];
    vec64_t tbl64[4];

    initial begin
        bit          a;
        int          nb, n;
        logic [31:0] ri;
        logic [2:0]  rm;
        logic [63:0] rp, ei;

        tbl[0]  = '{32'hFFF00093, 3'd1, 32'h100,      32'hFFFFFFFF, 32'h000000FF, 1'b0, 1'b0};
        tbl[1]  = '{32'hFE000EE3, 3'd3, 32'h200,      32'hFFFFFFFC, 32'h000001FC, 1'b0, 1'b0};
        tbl[2]  = '{32'h0020006F, 3'd5, 32'h1000,     32'h00000002, 32'h00001002, 1'b1, 1'b0};
        tbl[3]  = '{32'h02009093, 3'd7, 32'h0,        32'h00000000, 32'h00000000, 1'b0, 1'b1};
        tbl[4]  = '{32'hFE112E23, 3'd2, 32'h300,      32'hFFFFFFFC, 32'h000002FC, 1'b0, 1'b0};
        tbl[5]  = '{32'h12345037, 3'd4, 32'h10,       32'h12345000, 32'h12345010, 1'b0, 1'b0};
        tbl[6]  = '{32'h000FD073, 3'd6, 32'h40,       32'h0000001F, 32'h0000005F, 1'b0, 1'b0};
        tbl[7]  = '{32'hFFFFFFFF, 3'd0, 32'h8,        32'h00000000, 32'h00000008, 1'b0, 1'b0};
        tbl[8]  = '{32'h01F09093, 3'd7, 32'h0,        32'h0000001F, 32'h0000001F, 1'b0, 1'b0};
        tbl[9]  = '{32'hFE000EE3, 3'd3, 32'h202,      32'hFFFFFFFC, 32'h000001FE, 1'b1, 1'b0};
        tbl[10] = '{32'h00100093, 3'd1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};

        tbl64[0] = '{32'h800000B7, 3'd4, 64'h0, 64'hFFFFFFFF80000000,
                     64'hFFFFFFFF80000000, 1'b0, 1'b0};
        tbl64[1] = '{32'h02009093, 3'd7, 64'h0, 64'h20, 64'h20, 1'b0, 1'b0};
        tbl64[2] = '{32'hFFF00093, 3'd1, 64'h0000000100000000, 64'hFFFFFFFFFFFFFFFF,
                     64'h00000000FFFFFFFF, 1'b0, 1'b0};
        tbl64[3] = '{32'h0020006F, 3'd5, 64'hFFFFFFFFFFFFFFFE, 64'h2, 64'h0, 1'b0, 1'b0};

        flush = 0; in_valid = 0; in_instr = '0; in_mode = '0; in_pc = '0; out_ready = 0;
        flush_w = 0; in_valid_w = 0; in_instr_w = '0; in_mode_w = '0; in_pc_w = '0;
        out_ready_w = 0;

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_target", out_target, 0);
        chk("rst_misalign", out_misalign, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_out_valid_w", out_valid_w, 0);
        chk("rst_out_imm_w", out_imm_w, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_in_ready_w", in_ready_w, 1);
        @(posedge clk); #1;

        // Vector table, 32-bit; lane 1 repeats lane 0 at pc+4
        foreach (tbl[i]) begin
            in_valid = 1; in_instr = {tbl[i].instr, tbl[i].instr};
            in_mode = {tbl[i].mode, tbl[i].mode}; in_pc = tbl[i].pc; out_ready = 1;
            @(posedge clk); #1;
            in_valid = 0;
            chk($sformatf("v%0d_lat1", i), out_valid, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_imm0", i), out_imm[31:0], tbl[i].imm);
            chk($sformatf("v%0d_tgt0", i), out_target[31:0], tbl[i].tgt);
            chk($sformatf("v%0d_mis0", i), out_misalign[0], tbl[i].mis);
            chk($sformatf("v%0d_ill0", i), out_illegal[0], tbl[i].ill);
            chk($sformatf("v%0d_imm1", i), out_imm[63:32], tbl[i].imm);
            chk($sformatf("v%0d_tgt1", i), out_target[63:32], tbl[i].tgt + 32'd4);
            chk($sformatf("v%0d_mis1", i), out_misalign[1], tbl[i].mis);
            chk($sformatf("v%0d_ill1", i), out_illegal[1], tbl[i].ill);
            @(posedge clk); #1;
            chk($sformatf("v%0d_drain", i), out_valid, 0);
        end

        // Vector table, 64-bit
        foreach (tbl64[i]) begin
            in_valid_w = 1; in_instr_w = tbl64[i].instr; in_mode_w = tbl64[i].mode;
            in_pc_w = tbl64[i].pc; out_ready_w = 1;
            @(posedge clk); #1;
            in_valid_w = 0;
            @(posedge clk); #1;
            chk($sformatf("w%0d_valid", i), out_valid_w, 1);
            chk($sformatf("w%0d_imm", i), out_imm_w, tbl64[i].imm);
            chk($sformatf("w%0d_tgt", i), out_target_w, tbl64[i].tgt);
            chk($sformatf("w%0d_mis", i), out_misalign_w, tbl64[i].mis);
            chk($sformatf("w%0d_ill", i), out_illegal_w, tbl64[i].ill);
            @(posedge clk); #1;
        end

        // Random single beats on the 64-bit instance
        for (int k = 0; k < 24; k++) begin
            ri = $urandom; rm = 3'($urandom); rp = {$urandom, $urandom};
            in_valid_w = 1; in_instr_w = ri; in_mode_w = rm; in_pc_w = rp;
            @(posedge clk); #1;
            in_valid_w = 0;
            @(posedge clk); #1;
            ei = ref_imm(ri, rm, 1'b1);
            chk("w_rand_valid", out_valid_w, 1);
            chk("w_rand_imm", out_imm_w, ei);
            chk("w_rand_tgt", out_target_w, rp + ei);
            chk("w_rand_mis", out_misalign_w,
                ((rm == 3'd3) || (rm == 3'd5)) && ((rp + ei) % 4 != 0));
            chk("w_rand_ill", out_illegal_w, 0);
            @(posedge clk); #1;
        end

        // Backpressure: 4 beats, consumer stalled for the first 3 cycles
        nb = 0; n = 0;
        while (nb < 4 && n < 20) begin
            cyc(1'b1, {32'h00A00093 + 32'(nb) * 32'h00100000, 32'h00500093},
                6'o11, 32'h400 + 32'(16 * nb), (n >= 3), 1'b0, a);
            if (a) nb++;
            n++;
        end
        chk("bp_beats_accepted", 64'(nb), 4);
        repeat (4) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, a);

        // Flush with 2 beats in flight plus one presented
        cyc(1'b1, {32'h7FF00093, 32'h7FF00093}, 6'o11, 32'h800, 1'b0, 1'b0, a);
        cyc(1'b1, {32'h80000037, 32'h80000037}, 6'o44, 32'h900, 1'b0, 1'b0, a);
        cyc(1'b1, {32'h0020006F, 32'h0020006F}, 6'o55, 32'hA00, 1'b0, 1'b1, a);
        repeat (4) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, a);

        // Random streaming with backpressure and occasional flush
        repeat (400) begin
            cyc(($urandom % 10) < 7, {$urandom, $urandom}, 6'($urandom), $urandom,
                ($urandom % 10) < 7, ($urandom % 20) == 0, a);
        end

        // Reset mid-stream: fill the pipe, then drop rst_n between edges
        repeat (3) cyc(1'b1, {$urandom, $urandom}, 6'($urandom), $urandom, 1'b0, 1'b0, a);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_imm", out_imm, 0);
        chk("midrst_out_target", out_target, 0);
        chk("midrst_misalign", out_misalign, 0);
        chk("midrst_illegal", out_illegal, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (4) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, a);
        repeat (20) begin
            cyc(($urandom % 10) < 8, {$urandom, $urandom}, 6'($urandom), $urandom,
                ($urandom % 10) < 6, 1'b0, a);
        end
        repeat (4) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, a);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the decode-stage immediate generator. It accepts LANES instructions per beat, each with a 3-bit immediate-format mode. It produces XLEN-wide immediates, the PC-relative target (pc + imm) and fault flags through a two-stage elastic valid/ready pipeline with flush. It sits between instruction fetch/decode and the branch unit and ALU operand mux.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
LANES, 1, instructions per beat; legal values 1..4. Lane i uses pc = in_pc + 4*i.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of all in-flight beats.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_instr  input  LANES*32  instruction per lane; lane i is bits [32i+31:32i].
in_mode  input  LANES*3  format per lane: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 Z (CSR zimm), 111 SH (shamt).
in_pc  input  XLEN  PC of lane 0.
out_valid  output  1  output beat valid.
out_ready  input  1  consumer accepts the output beat.
out_imm  output  LANES*XLEN  immediate per lane.
out_target  output  LANES*XLEN  pc_i + imm_i per lane, modulo 2^XLEN.
out_misalign  output  LANES  target[1:0] != 0 for a B or J lane.
out_illegal  output  LANES  SH lane with XLEN=32 and instr[25]=1.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid, s2_valid and out_valid = 0. All data registers and outputs = 0. in_ready = 1 once reset is released.
- Immediate formation (combinational, before stage 1). "sx" means sign-extend instr[31] up to XLEN:
  - R: 0.
  - I: sx(instr[31:20]).
  - S: sx({instr[31:25], instr[11:7]}).
  - B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: sx({instr[31:12], 12'b0}); the upper 32 bits are sign-filled when XLEN=64.
  - J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Z: zero-extend instr[19:15].
  - SH: zero-extend instr[24:20] when XLEN=32; zero-extend instr[25:20] when XLEN=64.
- Stage 1 registers per lane: imm, lane pc, mode. Stage 2 registers per lane: imm, target = pc + imm (carry out discarded), misalign, illegal.
- Latency: exactly 2 cycles from an accepted input beat to out_valid, with no stalls. Throughput is 1 beat per cycle.
- Handshake:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1.
  - A beat is accepted when in_valid & in_ready.
  - out_valid = s2_valid.
  - While out_valid & !out_ready, all outputs hold stable. Data registers load only on advance.
- Misalign: asserted only for modes B/J when target[1:0] != 0 (no compressed-ISA support). Forced 0 for all other modes.
- Illegal: asserted only for SH with XLEN=32 and instr[25]=1. The immediate is still produced as defined.
- Flush: on the edge where flush=1, s1_valid and s2_valid are cleared, and any beat presented that cycle is dropped even if in_valid & in_ready. Flush takes priority over acceptance and advance. out_valid is 0 in the following cycle. Data registers may hold stale values but must not be flagged valid.
- Simultaneous out_ready and a full pipe: both stages advance and a new beat is accepted in the same cycle, with no bubble.
- Reset asserted mid-operation: all valids drop immediately (asynchronously). No partial beat emerges after rst_n is released.
- Lane independence: each lane's outputs depend only on its own instr and mode and on in_pc + 4*i.

Test Plan:
1. Single lane I-type, basic path: LANES=1, XLEN=32, instr 0xFFF00093, mode I, pc 0x100 -> two cycles later out_imm 0xFFFFFFFF, out_target 0x000000FF, misalign 0, illegal 0.
2. B-type: instr 0xFE000EE3, mode B, pc 0x200 -> out_imm 0xFFFFFFFC, out_target 0x1FC, misalign 0.
3. J-type misalign: instr 0x0020006F, mode J, pc 0x1000 -> out_imm 0x2, out_target 0x1002, misalign 1.
4. U-type at XLEN=64: instr 0x800000B7, mode U -> out_imm 0xFFFFFFFF80000000.
5. Illegal shamt at XLEN=32: instr 0x02009093, mode SH -> out_imm 0x0, illegal 1.
6. Backpressure, flush and reset:
   - Stream 4 beats with out_ready low for 3 cycles -> in_ready drops after 2 beats are held, outputs stay stable, and no beat is lost or duplicated.
   - Assert flush with 2 beats in flight -> next cycle out_valid 0, and the flushed beats never appear.
   - Drop rst_n mid-stream -> out_valid falls immediately and all outputs read 0.
